// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - N-master byte-wide memory bus arbiter with RAM/IO decode and read return routing
module mem_bus_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int ARB_MODE       = 0
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic [NUM_MASTERS-1:0]            m_req_in,
  input  logic [NUM_MASTERS-1:0]            m_wr_in,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_a_in,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dout_in,
  input  logic [NUM_MASTERS-1:0]            m_lock_in,
  output logic [NUM_MASTERS-1:0]            m_gnt_out,
  output logic [NUM_MASTERS-1:0]            m_dvalid_out,
  output logic [DATA_WIDTH-1:0]             m_din_out,
  output logic                              ram_en_out,
  output logic                              ram_r_nw_out,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_a_out,
  output logic [DATA_WIDTH-1:0]             ram_d_out,
  input  logic [DATA_WIDTH-1:0]             ram_d_in,
  output logic                              io_en_out,
  output logic [2:0]                        io_sel_out,
  output logic                              io_wr_out,
  output logic [DATA_WIDTH-1:0]             io_d_out,
  input  logic [DATA_WIDTH-1:0]             io_d_in
);

  localparam int IDX_W = $clog2(NUM_MASTERS);
  typedef logic [IDX_W-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(NUM_MASTERS - 1);

  idx_t                  rr_ptr;
  idx_t                  owner_q;
  logic                  lock_q;
  logic                  rst_q;
  logic                  pipe_v   [READ_LATENCY];
  idx_t                  pipe_idx [READ_LATENCY];
  logic                  pipe_io  [READ_LATENCY];

  logic                  gnt_any;
  idx_t                  gnt_idx;
  logic                  lock_active;
  logic [IDX_W:0]        cand;
  logic [ADDR_WIDTH-1:0] a_sel;
  logic [DATA_WIDTH-1:0] d_sel;
  logic                  wr_sel;
  logic                  is_io;
  logic                  out_v;
  idx_t                  out_idx;
  logic                  out_io;

  assign lock_active = lock_q & m_lock_in[owner_q];

  // Grants are held off during reset and the cycle after it.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!(rst_in || rst_q)) begin
      if (lock_active) begin
        if (m_req_in[owner_q]) begin
          gnt_any = 1'b1;
          gnt_idx = owner_q;
        end
      end else if (ARB_MODE == 0) begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
          if (m_req_in[i]) begin
            gnt_any = 1'b1;
            gnt_idx = idx_t'(i);
          end
        end
      end else begin
        for (int k = 0; k < NUM_MASTERS; k++) begin
          cand = {1'b0, rr_ptr} + (IDX_W+1)'(k);
          if (cand >= (IDX_W+1)'(NUM_MASTERS))
            cand = cand - (IDX_W+1)'(NUM_MASTERS);
          if (!gnt_any && m_req_in[cand[IDX_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[IDX_W-1:0];
          end
        end
      end
    end
  end

  always_comb begin
    m_gnt_out = '0;
    a_sel     = '0;
    d_sel     = '0;
    wr_sel    = 1'b0;
    if (gnt_any) begin
      m_gnt_out[gnt_idx] = 1'b1;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (gnt_idx == idx_t'(i)) begin
          a_sel  = m_a_in[i*ADDR_WIDTH +: ADDR_WIDTH];
          d_sel  = m_dout_in[i*DATA_WIDTH +: DATA_WIDTH];
          wr_sel = m_wr_in[i];
        end
      end
    end
  end

  assign is_io        = (a_sel[RAM_ADDR_WIDTH -: 2] == 2'b11);
  assign ram_en_out   = gnt_any & ~is_io;
  assign io_en_out    = gnt_any & is_io;
  assign io_wr_out    = io_en_out & wr_sel;
  assign ram_r_nw_out = ~(gnt_any & wr_sel);
  assign ram_a_out    = a_sel[RAM_ADDR_WIDTH-1:0];
  assign ram_d_out    = d_sel;
  assign io_sel_out   = a_sel[2:0];
  assign io_d_out     = d_sel;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr  <= '0;
      owner_q <= '0;
      lock_q  <= 1'b0;
      rst_q   <= 1'b1;
      for (int s = 0; s < READ_LATENCY; s++) begin
        pipe_v[s]   <= 1'b0;
        pipe_idx[s] <= '0;
        pipe_io[s]  <= 1'b0;
      end
    end else begin
      rst_q <= 1'b0;
      if (gnt_any)
        rr_ptr <= (gnt_idx == LAST_IDX) ? idx_t'(0) : gnt_idx + idx_t'(1);
      if (gnt_any && m_lock_in[gnt_idx]) begin
        lock_q  <= 1'b1;
        owner_q <= gnt_idx;
      end else if (lock_q && !m_lock_in[owner_q]) begin
        lock_q  <= 1'b0;
      end
      pipe_v[0]   <= gnt_any & ~wr_sel;
      pipe_idx[0] <= gnt_idx;
      pipe_io[0]  <= is_io;
      for (int s = 1; s < READ_LATENCY; s++) begin
        pipe_v[s]   <= pipe_v[s-1];
        pipe_idx[s] <= pipe_idx[s-1];
        pipe_io[s]  <= pipe_io[s-1];
      end
    end
  end

  // A read still in the pipe when reset arrives must not surface.
  assign out_v   = pipe_v[READ_LATENCY-1] & ~rst_in;
  assign out_idx = pipe_idx[READ_LATENCY-1];
  assign out_io  = pipe_io[READ_LATENCY-1];

  always_comb begin
    m_dvalid_out = '0;
    m_din_out    = '0;
    if (out_v) begin
      m_dvalid_out[out_idx] = 1'b1;
      m_din_out = out_io ? io_d_in : ram_d_in;
    end
  end

endmodule
